// File: rtl/scan_pkg.sv
// Shared state encoding and width helpers for the averaging matrix scanner.
package scan_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t DAC_ST = 3'd1;
    localparam state_t DAC_WT = 3'd2;
    localparam state_t SETTLE = 3'd3;
    localparam state_t ADC_ST = 3'd4;
    localparam state_t ADC_WT = 3'd5;
    localparam state_t EMIT   = 3'd6;
    localparam state_t NEXT   = 3'd7;

    // A 1-entry dimension still gets a 1-bit select held at zero.
    function automatic int sel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int timer_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter; done is raised during the last cycle of the settle window.
module settle_timer
    import scan_pkg::*;
#(
    parameter int CYCLES = 1000,
    localparam int W = timer_w(CYCLES)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (load_i) begin
            cnt <= W'(CYCLES);
        end else if (en_i && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Raising done at 1 makes the waiting state last exactly CYCLES cycles.
    assign done_o = (cnt <= W'(1));

endmodule

// File: rtl/fsm_matrix_scan_avg.sv
// Bolometer matrix scanner: bias DAC once per frame, settle, average 2**NSAMP_LOG2 ADC samples per pixel.
module fsm_matrix_scan_avg
    import scan_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int ADC_W      = 12,
    parameter int NSAMP_LOG2 = 2,
    parameter int SETTLE_CYC = 1000,
    localparam int RW = sel_w(ROWS),
    localparam int CW = sel_w(COLS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             cont_i,
    output logic             stdac_o,
    input  logic             eodac_i,
    output logic             stadc_o,
    input  logic             eoadc_i,
    input  logic [ADC_W-1:0] adc_data_i,
    output logic [RW-1:0]    row_o,
    output logic [CW-1:0]    col_o,
    output logic [ADC_W-1:0] pix_data_o,
    output logic             pix_valid_o,
    input  logic             pix_ready_i,
    output logic             eof_o,
    output logic             eos_o
);

    localparam int AW = ADC_W + NSAMP_LOG2;
    localparam int SW = NSAMP_LOG2 + 1;
    localparam logic [SW-1:0] LAST_SAMPLE = SW'((1 << NSAMP_LOG2) - 1);
    localparam logic [RW-1:0] LAST_ROW    = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL    = CW'(COLS - 1);

    state_t          state;
    state_t          state_nx;
    logic [SW-1:0]   sample_cnt;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_sum;
    logic [ADC_W-1:0] pix_avg;
    logic            last_col;
    logic            last_row;
    logic            last_sample;
    logic            timer_load;
    logic            timer_done;

    assign acc_sum     = acc + AW'(adc_data_i);
    assign pix_avg     = acc_sum[AW-1:NSAMP_LOG2];
    assign last_col    = (col_o == LAST_COL);
    assign last_row    = (row_o == LAST_ROW);
    assign last_sample = (sample_cnt == LAST_SAMPLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_i) state_nx = DAC_ST;
            DAC_ST:  state_nx = DAC_WT;
            DAC_WT:  if (eodac_i) state_nx = SETTLE;
            SETTLE:  if (timer_done) state_nx = ADC_ST;
            ADC_ST:  state_nx = ADC_WT;
            ADC_WT:  if (eoadc_i) state_nx = last_sample ? EMIT : ADC_ST;
            EMIT:    if (pix_ready_i) state_nx = NEXT;
            NEXT: begin
                if (!last_col)      state_nx = ADC_ST;
                else if (!last_row) state_nx = SETTLE;
                else                state_nx = cont_i ? DAC_ST : IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (abort_i) state_nx = IDLE;
    end

    assign timer_load = (state_nx == SETTLE) && (state != SETTLE);

    settle_timer #(.CYCLES(SETTLE_CYC)) u_settle (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (timer_load),
        .en_i   (state == SETTLE),
        .done_o (timer_done)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            row_o      <= '0;
            col_o      <= '0;
            sample_cnt <= '0;
            acc        <= '0;
            pix_data_o <= '0;
        end else begin
            state <= state_nx;
            if (abort_i && state != IDLE) begin
                row_o      <= '0;
                col_o      <= '0;
                sample_cnt <= '0;
                acc        <= '0;
            end else begin
                case (state)
                    ADC_WT: begin
                        if (eoadc_i) begin
                            acc        <= acc_sum;
                            sample_cnt <= sample_cnt + 1'b1;
                            if (last_sample) pix_data_o <= pix_avg;
                        end
                    end
                    NEXT: begin
                        acc        <= '0;
                        sample_cnt <= '0;
                        if (!last_col) begin
                            col_o <= col_o + 1'b1;
                        end else begin
                            col_o <= '0;
                            row_o <= last_row ? '0 : row_o + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Handshake: pix_data_o is stable while pix_valid_o is high; a pixel moves on the first edge with valid & ready.
    assign stdac_o     = (state == DAC_ST);
    assign stadc_o     = (state == ADC_ST);
    assign pix_valid_o = (state == EMIT);
    assign eos_o       = (state == IDLE);
    assign eof_o       = (state == NEXT) && last_col && last_row && !abort_i;

endmodule

// File: tb/tb_fsm_matrix_scan_avg.sv
// Directed bench for fsm_matrix_scan_avg on a 2x3 matrix with 4-sample averaging and a 5-cycle settle.
module tb_fsm_matrix_scan_avg;

    localparam int ROWS = 2;
    localparam int COLS = 3;
    localparam int ADC_W = 12;
    localparam int NSL = 2;
    localparam int SETTLE = 5;

    logic             clk;
    logic             rst_i;
    logic             start_i;
    logic             abort_i;
    logic             cont_i;
    logic             stdac_o;
    logic             eodac_i;
    logic             stadc_o;
    logic             eoadc_i;
    logic [ADC_W-1:0] adc_data_i;
    logic [0:0]       row_o;
    logic [1:0]       col_o;
    logic [ADC_W-1:0] pix_data_o;
    logic             pix_valid_o;
    logic             pix_ready_i;
    logic             eof_o;
    logic             eos_o;

    fsm_matrix_scan_avg #(
        .ROWS(ROWS), .COLS(COLS), .ADC_W(ADC_W), .NSAMP_LOG2(NSL), .SETTLE_CYC(SETTLE)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .cont_i      (cont_i),
        .stdac_o     (stdac_o),
        .eodac_i     (eodac_i),
        .stadc_o     (stadc_o),
        .eoadc_i     (eoadc_i),
        .adc_data_i  (adc_data_i),
        .row_o       (row_o),
        .col_o       (col_o),
        .pix_data_o  (pix_data_o),
        .pix_valid_o (pix_valid_o),
        .pix_ready_i (pix_ready_i),
        .eof_o       (eof_o),
        .eos_o       (eos_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard queues: averaged value and row*16+col per expected pixel, raster order
    logic [ADC_W-1:0] exp_q[$];
    int               exp_rc_q[$];

    task automatic push_frame(input int npix, input logic sat);
        for (int i = 0; i < npix; i++) begin
            exp_q.push_back(sat ? 12'hFFF : 12'((i / COLS) * 16 + (i % COLS) * 4 + 1));
            exp_rc_q.push_back((i / COLS) * 16 + (i % COLS));
        end
    endtask

    // DAC model: eodac_i one cycle after the strobe
    initial begin
        eodac_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stdac_o) begin
                @(posedge clk); #1 eodac_i = 1'b1;
                @(posedge clk); #1 eodac_i = 1'b0;
            end
        end
    end

    // ADC model: eoadc_i two cycles after stadc_o, sample = row*16 + col*4 + k
    logic adc_sat = 1'b0;
    initial begin
        int k;
        int pend;
        int base;
        k = 0;
        pend = 0;
        eoadc_i = 1'b0;
        adc_data_i = '0;
        forever begin
            @(posedge clk); #1;
            eoadc_i = 1'b0;
            if (eos_o) k = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    base = int'(row_o) * 16 + int'(col_o) * 4;
                    adc_data_i = adc_sat ? 12'hFFF : 12'(base + (k % 4));
                    eoadc_i = 1'b1;
                    k++;
                end
            end
            if (stadc_o) pend = 2;
        end
    end

    // Monitor: timing bookkeeping and pixel scoreboard
    int cyc = 0;
    int dac_cyc = 0, row_cyc = 0, eof_cyc = -100;
    int dac_gap = -1, row_gap = -1, eof_to_stdac = -1;
    int stadc_cnt = 0, eof_cnt = 0, valid_cnt = 0;
    logic pend_dac = 1'b0, pend_row = 1'b0;
    logic [0:0] prev_row = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (eodac_i) begin
            pend_dac = 1'b1;
            dac_cyc = cyc;
        end
        if (row_o != prev_row) begin
            if (row_o != 1'b0) begin
                pend_row = 1'b1;
                row_cyc = cyc;
            end
            prev_row = row_o;
        end
        if (stadc_o) begin
            stadc_cnt++;
            // Gaps count the SETTLE cycles between the trigger and the ADC strobe
            if (pend_dac) begin
                dac_gap = cyc - dac_cyc - 1;
                pend_dac = 1'b0;
            end
            if (pend_row) begin
                row_gap = cyc - row_cyc;
                pend_row = 1'b0;
            end
        end
        if (eof_o) begin
            eof_cnt++;
            eof_cyc = cyc;
        end
        if (stdac_o) eof_to_stdac = cyc - eof_cyc;
        if (pix_valid_o) valid_cnt++;
        if (pix_valid_o && pix_ready_i && !rst_i) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_pixel", exp_q.size(), 1);
            end else begin
                check("pix_data", pix_data_o, exp_q.pop_front());
                check("pix_rc", int'(row_o) * 16 + int'(col_o), exp_rc_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic start_frame();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
    endtask

    task automatic wait_eos(input logic lvl, input string tag);
        int n = 0;
        while (eos_o !== lvl && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, eos_o, lvl);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int e;
        int saved;
        int saved2;
        logic [ADC_W-1:0] held;

        rst_i = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        cont_i = 1'b0;
        pix_ready_i = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_eos", eos_o, 1'b1);
        check("rst_stdac", stdac_o, 1'b0);
        check("rst_stadc", stadc_o, 1'b0);
        check("rst_valid", pix_valid_o, 1'b0);
        check("rst_eof", eof_o, 1'b0);
        check("rst_row", row_o, 1'b0);
        check("rst_col", col_o, 2'd0);
        check("rst_pix", pix_data_o, 12'h000);
        rst_i = 1'b0;

        // Frame 1: plain raster, sink always ready
        push_frame(6, 1'b0);
        pix_ready_i = 1'b1;
        saved = eof_cnt;
        saved2 = valid_cnt;
        start_frame();
        wait_eos(1'b0, "f1_busy");
        wait_eos(1'b1, "f1_done");
        check("f1_eof_count", eof_cnt - saved, 1);
        check("f1_valid_cycles", valid_cnt - saved2, 6);
        check("f1_dac_settle", dac_gap, SETTLE);
        check("f1_row_settle", row_gap, SETTLE);
        check("f1_sb_drain", exp_q.size(), 0);
        check("f1_end_rc", int'(row_o) * 16 + int'(col_o), 0);

        // Frame 2: backpressure on the first pixel
        push_frame(6, 1'b0);
        @(posedge clk); #1 pix_ready_i = 1'b0;
        start_frame();
        n = 0;
        while (!pix_valid_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", pix_valid_o, 1'b1);
        held = pix_data_o;
        saved = stadc_cnt;
        e = 0;
        repeat (10) begin
            @(negedge clk);
            if (pix_valid_o && pix_data_o == held) e++;
        end
        check("bp_valid_held", e, 10);
        check("bp_data", held, 12'h001);
        check("bp_no_stadc", stadc_cnt - saved, 0);
        @(posedge clk); #1 pix_ready_i = 1'b1;
        wait_eos(1'b1, "f2_done");
        check("f2_sb_drain", exp_q.size(), 0);

        // Frames 3+4: continuous mode, cont_i dropped after the first eof
        push_frame(6, 1'b0);
        push_frame(6, 1'b0);
        saved = eof_cnt;
        @(posedge clk); #1 cont_i = 1'b1;
        start_frame();
        n = 0;
        while (!eof_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("cont_eof1", eof_o, 1'b1);
        @(posedge clk); #1 cont_i = 1'b0;
        e = 0;
        n = 0;
        @(negedge clk);
        while (!eof_o && n < 3000) begin
            if (eos_o) e++;
            @(negedge clk);
            n++;
        end
        check("cont_eof2", eof_o, 1'b1);
        check("cont_eos_low", e, 0);
        check("cont_eof_to_stdac", eof_to_stdac, 1);
        wait_eos(1'b1, "cont_done");
        check("cont_eof_count", eof_cnt - saved, 2);
        check("cont_sb_drain", exp_q.size(), 0);

        // Frame 5: abort while waiting for the ADC at pixel (1,2)
        push_frame(5, 1'b0);
        saved = eof_cnt;
        start_frame();
        n = 0;
        while (!(row_o == 1'b1 && col_o == 2'd2 && stadc_o) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("ab_at_pixel_12", {row_o, col_o, stadc_o}, 4'b1101);
        @(posedge clk); #1 abort_i = 1'b1;
        @(posedge clk); #1 abort_i = 1'b0;
        @(negedge clk);
        check("ab_eos", eos_o, 1'b1);
        check("ab_valid", pix_valid_o, 1'b0);
        check("ab_rc", int'(row_o) * 16 + int'(col_o), 0);
        repeat (4) @(negedge clk);
        check("ab_still_idle", eos_o, 1'b1);
        check("ab_no_eof", eof_cnt - saved, 0);
        check("ab_sb_drain", exp_q.size(), 0);

        // Frame 6: restart after abort begins again at (0,0)
        push_frame(6, 1'b0);
        start_frame();
        wait_eos(1'b0, "f6_busy");
        wait_eos(1'b1, "f6_done");
        check("f6_sb_drain", exp_q.size(), 0);

        // Frame 7: full-scale samples must not overflow the average
        adc_sat = 1'b1;
        push_frame(6, 1'b1);
        start_frame();
        wait_eos(1'b0, "f7_busy");
        wait_eos(1'b1, "f7_done");
        check("f7_sb_drain", exp_q.size(), 0);

        // Frame 8: asynchronous reset in the middle of row 1
        push_frame(3, 1'b1);
        start_frame();
        n = 0;
        while (row_o != 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("ar_row1_reached", row_o, 1'b1);
        check("ar_pre_pix", pix_data_o, 12'hFFF);
        check("ar_sb_drain", exp_q.size(), 0);
        #2 rst_i = 1'b1;
        #1;
        check("ar_eos", eos_o, 1'b1);
        check("ar_row", row_o, 1'b0);
        check("ar_col", col_o, 2'd0);
        check("ar_pix", pix_data_o, 12'h000);
        check("ar_valid", pix_valid_o, 1'b0);
        check("ar_stadc", stadc_o, 1'b0);
        @(negedge clk);
        rst_i = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
